// File: rtl/pipe_stage_chain_if.sv
// Bus between the pipeline stage chain and its neighbouring stages.
// The master drives incoming instruction metadata/payload; the slave returns the last-stage view.
interface pipe_stage_chain_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TNEW_W = 3,
    parameter int unsigned A3_W   = 5
);
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic              rfen_in;
    logic [A3_W-1:0]   a3_in;
    logic [TNEW_W-1:0] tnew_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic              rfen_out;
    logic [A3_W-1:0]   a3_out;
    logic [TNEW_W-1:0] tnew_out;
    logic [DATA_W-1:0] data_out;
    logic              fwd_ready;

    modport master (
        output stall, flush, valid_in, rfen_in, a3_in, tnew_in, data_in,
        input  valid_out, rfen_out, a3_out, tnew_out, data_out, fwd_ready
    );

    modport slave (
        input  stall, flush, valid_in, rfen_in, a3_in, tnew_in, data_in,
        output valid_out, rfen_out, a3_out, tnew_out, data_out, fwd_ready
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep pipeline register chain with stall, flush, Tnew ageing and forwarding-ready flag.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_chain #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned TNEW_W = 3,
    parameter int unsigned A3_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    pipe_stage_chain_if.slave   bus
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         bubble_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              rfen;
        logic [A3_W-1:0]   a3;
        logic [TNEW_W-1:0] tnew;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t stg_q [DEPTH];
    stage_t stg_d [DEPTH];
    stage_t in_stage;
    stage_t last;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    always_comb begin
        in_stage = '0;
        if (bus.valid_in) begin
            in_stage.valid = 1'b1;
            in_stage.rfen  = bus.rfen_in;
            in_stage.a3    = bus.a3_in;
            in_stage.tnew  = bus.tnew_in;
            in_stage.data  = bus.data_in;
        end
    end

    // Flush overrides stall only for stage 0; downstream stages advance so the chain drains.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stg_d[k] = stg_q[k];
        end
        if (bus.flush) begin
            stg_d[0] = '0;
        end else if (bus.stall) begin
            stg_d[0].tnew = sat_dec(stg_q[0].tnew);
        end else begin
            stg_d[0] = in_stage;
        end
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (bus.stall && !bus.flush) begin
                stg_d[k].tnew = sat_dec(stg_q[k].tnew);
            end else begin
                stg_d[k]      = stg_q[k-1];
                stg_d[k].tnew = sat_dec(stg_q[k-1].tnew);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    always_comb begin
        last          = stg_q[DEPTH-1];
        bus.valid_out = last.valid;
        bus.rfen_out  = last.valid & last.rfen;
        bus.a3_out    = last.valid ? last.a3 : '0;
        bus.tnew_out  = sat_dec(last.tnew);
        bus.data_out  = last.data;
        bus.fwd_ready = bus.valid_out & bus.rfen_out & (bus.a3_out != '0) & (bus.tnew_out == '0);
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.stall && !bus.flush && bus.valid_out && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((bus.flush || (!bus.stall && !bus.valid_in)) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: three chains (DEPTH 1/2/3) share one stimulus stream; each test checks one of them.
// PIPE_STAGE_PERF_CNT_EN additionally checks the performance counters.
module tb_pipe_stage_chain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.DATA_W(32), .TNEW_W(3), .A3_W(5)) if1 ();
    pipe_stage_chain_if #(.DATA_W(32), .TNEW_W(3), .A3_W(5)) if2 ();
    pipe_stage_chain_if #(.DATA_W(32), .TNEW_W(3), .A3_W(5)) if3 ();

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] sc1, bc1, sc2, bc2, sc3, bc3;
`endif

    pipe_stage_chain #(.DATA_W(32), .DEPTH(1), .TNEW_W(3), .A3_W(5)) u_d1 (
        .clk(clk), .reset(rst_n), .bus(if1.slave)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .stall_cnt(sc1), .bubble_cnt(bc1)
`endif
    );
    pipe_stage_chain #(.DATA_W(32), .DEPTH(2), .TNEW_W(3), .A3_W(5)) u_d2 (
        .clk(clk), .reset(rst_n), .bus(if2.slave)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .stall_cnt(sc2), .bubble_cnt(bc2)
`endif
    );
    pipe_stage_chain #(.DATA_W(32), .DEPTH(3), .TNEW_W(3), .A3_W(5)) u_d3 (
        .clk(clk), .reset(rst_n), .bus(if3.slave)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .stall_cnt(sc3), .bubble_cnt(bc3)
`endif
    );

    typedef struct {
        logic        stall, flush, vin, rfen;
        logic [4:0]  a3;
        logic [2:0]  tnew;
        logic [31:0] data;
        logic        ev, erf;
        logic [4:0]  ea3;
        logic [2:0]  etn;
        logic [31:0] ed;
        logic        efwd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic r,
                         input logic [4:0] a, input logic [2:0] t, input logic [31:0] d);
        if1.stall = s; if1.flush = f; if1.valid_in = v; if1.rfen_in = r;
        if1.a3_in = a; if1.tnew_in = t; if1.data_in = d;
        if2.stall = s; if2.flush = f; if2.valid_in = v; if2.rfen_in = r;
        if2.a3_in = a; if2.tnew_in = t; if2.data_in = d;
        if3.stall = s; if3.flush = f; if3.valid_in = v; if3.rfen_in = r;
        if3.a3_in = a; if3.tnew_in = t; if3.data_in = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // DEPTH=1 vectors: inputs applied before an edge, outputs checked just after it.
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 3'd2, 32'hDEADBEEF, 1'b1, 1'b1, 5'd8, 3'd1, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 3'd5, 32'h00001111, 1'b1, 1'b1, 5'd8, 3'd0, 32'hDEADBEEF, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 3'd5, 32'h00001111, 1'b1, 1'b1, 5'd8, 3'd0, 32'hDEADBEEF, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 3'd0, 32'h12345678, 1'b1, 1'b1, 5'd0, 3'd0, 32'h12345678, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 3'd4, 32'h0000AAAA, 1'b0, 1'b0, 5'd0, 3'd0, 32'h00000000, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 3'd0, 32'h00000055, 1'b1, 1'b0, 5'd4, 3'd0, 32'h00000055, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 3'd7, 32'h0000CAFE, 1'b1, 1'b1, 5'd7, 3'd6, 32'h0000CAFE, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 3'd1, 32'h0000BEEF, 1'b0, 1'b0, 5'd0, 3'd0, 32'h00000000, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 3'd1, 32'h00000001, 1'b1, 1'b1, 5'd2, 3'd0, 32'h00000001, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h00000000, 1'b1, 1'b1, 5'd2, 3'd0, 32'h00000001, 1'b1};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
        #1;
        chk("rst_valid_d1", 32'(if1.valid_out), 32'd0);
        chk("rst_data_d3", if3.data_out, 32'd0);
        chk("rst_fwd_d2", 32'(if2.fwd_ready), 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].stall, tbl[i].flush, tbl[i].vin, tbl[i].rfen, tbl[i].a3, tbl[i].tnew, tbl[i].data);
            step();
            chk($sformatf("v%0d_valid", i), 32'(if1.valid_out), 32'(tbl[i].ev));
            chk($sformatf("v%0d_rfen", i), 32'(if1.rfen_out), 32'(tbl[i].erf));
            chk($sformatf("v%0d_a3", i), 32'(if1.a3_out), 32'(tbl[i].ea3));
            chk($sformatf("v%0d_tnew", i), 32'(if1.tnew_out), 32'(tbl[i].etn));
            chk($sformatf("v%0d_data", i), if1.data_out, tbl[i].ed);
            chk($sformatf("v%0d_fwd", i), 32'(if1.fwd_ready), 32'(tbl[i].efwd));
        end

        // DEPTH=3 latency and Tnew ageing across stages
        reset_pulse();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 3'd3, 32'h0BADF00D);
        step();
        chk("d3_e1_valid", 32'(if3.valid_out), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
        step();
        chk("d3_e2_valid", 32'(if3.valid_out), 32'd0);
        step();
        chk("d3_e3_valid", 32'(if3.valid_out), 32'd1);
        chk("d3_e3_a3", 32'(if3.a3_out), 32'd31);
        chk("d3_e3_tnew", 32'(if3.tnew_out), 32'd0);
        chk("d3_e3_fwd", 32'(if3.fwd_ready), 32'd1);
        chk("d3_e3_data", if3.data_out, 32'h0BADF00D);
        step();
        chk("d3_e4_valid", 32'(if3.valid_out), 32'd0);

        // DEPTH=2: stall holds, flush breaks stall and drains
        reset_pulse();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 3'd0, 32'h0000000B);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 3'd4, 32'h0000000A);
        step();
        chk("d2_B_data", if2.data_out, 32'h0000000B);
        chk("d2_B_a3", 32'(if2.a3_out), 32'd2);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 3'd0, 32'h00000099);
        step();
        chk("d2_hold_data", if2.data_out, 32'h0000000B);
        chk("d2_hold_valid", 32'(if2.valid_out), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 3'd0, 32'h00000099);
        step();
        chk("d2_fl1_data", if2.data_out, 32'h0000000A);
        chk("d2_fl1_a3", 32'(if2.a3_out), 32'd1);
        // A: loaded tnew 4, aged by the stall edge to 3, advanced (dec) to 2, output dec -> 1
        chk("d2_fl1_tnew", 32'(if2.tnew_out), 32'd1);
        step();
        chk("d2_fl2_valid", 32'(if2.valid_out), 32'd0);
        chk("d2_fl2_rfen", 32'(if2.rfen_out), 32'd0);

        // Asynchronous reset while DEPTH=3 is full
        reset_pulse();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 3'd0, 32'h00C0FFEE);
        step(); step(); step();
        chk("full_valid_d3", 32'(if3.valid_out), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 3'd0, 32'h00C0FFEE);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid_d3", 32'(if3.valid_out), 32'd0);
        chk("arst_data_d3", if3.data_out, 32'd0);
        chk("arst_a3_d3", 32'(if3.a3_out), 32'd0);
        chk("arst_valid_d1", 32'(if1.valid_out), 32'd0);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 3'd0, 32'h00C0FFEE);
        step();
        chk("post_rst_valid_d1", 32'(if1.valid_out), 32'd1);
        chk("post_rst_fwd_d1", 32'(if1.fwd_ready), 32'd1);

`ifdef PIPE_STAGE_PERF_CNT_EN
        reset_pulse();
        chk("pc_rst_stall", sc1, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 3'd0, 32'h1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 3'd0, 32'h1);
        for (int i = 0; i < 4; i++) step();
        chk("pc_stall4", sc1, 32'd4);
        chk("pc_bubble0", bc1, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 3'd0, 32'h1);
        step();
        chk("pc_stall_flush", sc1, 32'd4);
        chk("pc_bubble1", bc1, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("pc_clr_stall", sc1, 32'd0);
        chk("pc_clr_bubble", bc1, 32'd0);
        #1 rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised successor to the single inter-stage pipeline register. It is a DEPTH-deep chain of stage registers carrying a generic payload plus hazard metadata: valid, RF write enable, destination register and Tnew. It adds stall (hold), flush (bubble insertion), Tnew ageing while held, and a forwarding-ready flag. It sits between any two MIPS pipeline stages (D/E, E/M, M/W); DEPTH>1 models multi-cycle units.

Parameters:
DATA_W, 32, width of the opaque payload bus (ALU result, store data, PC+8, control bits concatenated by the caller)
DEPTH, 1, number of chained stage registers, legal 1..4
TNEW_W, 3, width of the Tnew field
A3_W, 5, width of the destination-register field

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold every stage this cycle
flush  in  1  load a bubble into stage 0 this cycle
valid_in  in  1  incoming instruction is real
rfen_in  in  1  incoming instruction writes the RF
a3_in  in  A3_W  incoming destination register
tnew_in  in  TNEW_W  incoming Tnew, cycles until result is ready
data_in  in  DATA_W  incoming payload
valid_out  out  1  last-stage valid
rfen_out  out  1  last-stage RF write enable, gated by valid
a3_out  out  A3_W  last-stage destination, 0 when not valid
tnew_out  out  TNEW_W  saturating (raw-1) of the last stage
data_out  out  DATA_W  last-stage payload
fwd_ready  out  1  valid_out & rfen_out & (a3_out!=0) & (tnew_out==0)

Behaviour:
- Each stage k holds {valid, rfen, a3, tnew_raw, data}. Bubble = all fields zero.
- Reset low: all stages become bubbles immediately (async). All outputs read 0 while reset is low and until the first load.
- Priority per rising edge (reset deasserted): flush > stall > advance.
- Advance (stall=0, flush=0): stage 0 loads the inputs; tnew_raw0 = tnew_in. Stage k>0 loads stage k-1, with tnew_raw_k = sat_dec(tnew_raw_{k-1}).
- sat_dec(x) = (x==0) ? 0 : x-1. The counter never wraps.
- Stall only: every stage keeps valid/rfen/a3/data. Every stage tnew_raw <= sat_dec(tnew_raw), so a held instruction ages by one per cycle.
- Flush: stage 0 loads a bubble regardless of stall. Stages k>0 advance normally, even if stall=1. Flush therefore breaks a stall and drains the chain.
- Inputs ignore valid_in=0: stage 0 captures a bubble in that case (rfen, a3 and tnew are forced to 0).
- Latency: DEPTH cycles from an accepted input to valid_out, with no stall.
- Outputs are purely combinational from the last stage. There is no combinational path from any input to any output.
- tnew_out = sat_dec(tnew_raw_last). For DEPTH=1 this equals the single-register behaviour: the stored value minus one, floored at 0.
- Reset asserted mid-stall or mid-flush: the chain clears immediately. The first edge after release obeys the normal priority.

Optional Feature:
Macro PIPE_STAGE_PERF_CNT_EN.
- Defined: two extra outputs, stall_cnt (32) and bubble_cnt (32).
  - stall_cnt increments on every edge with stall=1 & flush=0 & valid_out=1.
  - bubble_cnt increments on every edge where stage 0 loads a bubble (flush=1, or valid_in=0 on advance).
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist, and core behaviour is identical.

Test Plan:
1. DEPTH=1: load valid_in=1, rfen=1, a3=5'd8, tnew=3'd2, data=32'hDEADBEEF. Next cycle -> valid_out=1, a3_out=8, tnew_out=1, data_out=DEADBEEF, fwd_ready=0.
2. DEPTH=1: after test 1, hold stall=1 for 2 cycles. tnew_out steps 1->0->0 and data stays DEADBEEF. fwd_ready=1 from the first stalled edge onward.
3. DEPTH=3: load tnew=3'd3, a3=5'd31, then bubbles. After exactly 3 edges -> valid_out=1, tnew_out=0, fwd_ready=1. Cycles 1-2 show valid_out=0.
4. Flush with stall=1 while DEPTH=2 holds instructions A (stage0) and B (stage1). Next edge -> stage1=A, stage0=bubble; after a further flush edge, valid_out=0.
5. Load a3=0, rfen=1, tnew=0 -> valid_out=1 but fwd_ready=0. Load valid_in=0, rfen=1, a3=9 -> rfen_out=0, a3_out=0.
6. Assert reset low asynchronously between edges while the chain is full -> all outputs 0 before the next edge. With PIPE_STAGE_PERF_CNT_EN: 4 stalled edges with valid_out=1 -> stall_cnt=4, and reset -> 0.
